// File: rtl/julia_pkg.sv
// Shared constants and state encoding for the Julia-set engine.
// All fixed-point values are signed Q4.28.
package julia_pkg;

    localparam int unsigned FRAC_BITS = 28;
    localparam logic [36:0] ESCAPE_TH = 37'd4 << FRAC_BITS;

    localparam logic [31:0] X_MIN_DEF = 32'hE666_6666;  // -1.6
    localparam logic [31:0] Y_MAX_DEF = 32'h1333_3333;  // +1.2
    localparam logic [31:0] STEP_DEF  = 32'h0051_EB85;  // ~0.02

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StInit = 3'd1,
        StIter = 3'd2,
        StEmit = 3'd3,
        StDone = 3'd4
    } state_e;

endpackage

// File: rtl/julia_step.sv
// One combinational z <- z^2 + c step in Q4.28, plus the |z|^2 > 4 escape test on the
// incoming z.
module julia_step
    import julia_pkg::*;
(
    input  logic signed [31:0] zr_i,
    input  logic signed [31:0] zi_i,
    input  logic        [31:0] cr_i,
    input  logic        [31:0] ci_i,
    output logic        [31:0] zr_o,
    output logic        [31:0] zi_o,
    output logic               escape_o
);

    logic signed [63:0] p_rr;
    logic signed [63:0] p_ii;
    logic signed [63:0] p_ri;
    logic signed [63:0] re_full;
    logic signed [63:0] im_full;
    logic        [36:0] mag;
    logic               unused_bits;

    always_comb begin
        p_rr    = 64'(zr_i) * 64'(zr_i);
        p_ii    = 64'(zi_i) * 64'(zi_i);
        p_ri    = 64'(zr_i) * 64'(zi_i);
        // Combine at full precision, then truncate once to Q4.28; overflow wraps.
        re_full = p_rr - p_ii;
        im_full = p_ri <<< 1;
        zr_o    = re_full[FRAC_BITS +: 32] + cr_i;
        zi_o    = im_full[FRAC_BITS +: 32] + ci_i;

        mag      = {1'b0, p_rr[63:FRAC_BITS]} + {1'b0, p_ii[63:FRAC_BITS]};
        escape_o = mag > ESCAPE_TH;

        unused_bits = ^{p_rr[FRAC_BITS-1:0], p_ii[FRAC_BITS-1:0],
                        re_full[63:60], re_full[FRAC_BITS-1:0],
                        im_full[63:60], im_full[FRAC_BITS-1:0]};
    end

endmodule

// File: rtl/julia_engine.sv
// Raster-scans an H_RES x V_RES grid, iterating z <- z^2 + c per pixel and emitting the
// escape count over a registered valid/ready port.
module julia_engine
    import julia_pkg::*;
#(
    parameter int unsigned H_RES    = 160,
    parameter int unsigned V_RES    = 120,
    parameter int unsigned MAX_ITER = 255,
    parameter int unsigned ITER_W   = 8,
    parameter logic [31:0] X_MIN    = X_MIN_DEF,
    parameter logic [31:0] Y_MAX    = Y_MAX_DEF,
    parameter logic [31:0] STEP     = STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       rC,
    input  logic [31:0]       iC,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_x,
    output logic [7:0]        out_y,
    output logic [ITER_W-1:0] out_iter,
    output logic              frame_done
);

    localparam logic [7:0]        LastX   = 8'(H_RES - 1);
    localparam logic [7:0]        LastY   = 8'(V_RES - 1);
    localparam logic [ITER_W-1:0] IterCap = ITER_W'(MAX_ITER);

    state_e            state_q, state_d;
    logic [31:0]       cr_q, cr_d, ci_q, ci_d;
    logic [31:0]       zr_q, zr_d, zi_q, zi_d;
    logic [31:0]       cur_re_q, cur_re_d, cur_im_q, cur_im_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [7:0]        x_q, x_d, y_q, y_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_x_q, out_x_d, out_y_q, out_y_d;
    logic [ITER_W-1:0] out_iter_q, out_iter_d;
    logic              frame_done_q, frame_done_d;

    logic [31:0] zr_next, zi_next;
    logic        escape;

    julia_step u_step (
        .zr_i     (zr_q),
        .zi_i     (zi_q),
        .cr_i     (cr_q),
        .ci_i     (ci_q),
        .zr_o     (zr_next),
        .zi_o     (zi_next),
        .escape_o (escape)
    );

    always_comb begin
        state_d      = state_q;
        cr_d         = cr_q;
        ci_d         = ci_q;
        zr_d         = zr_q;
        zi_d         = zi_q;
        cur_re_d     = cur_re_q;
        cur_im_d     = cur_im_q;
        iter_d       = iter_q;
        x_d          = x_q;
        y_d          = y_q;
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_iter_d   = out_iter_q;
        frame_done_d = frame_done_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cr_d     = rC;
                    ci_d     = iC;
                    x_d      = '0;
                    y_d      = '0;
                    cur_re_d = X_MIN;
                    cur_im_d = Y_MAX;
                    state_d  = StInit;
                end
            end
            StInit: begin
                zr_d    = cur_re_q;
                zi_d    = cur_im_q;
                iter_d  = '0;
                state_d = StIter;
            end
            StIter: begin
                if (escape || (iter_q == IterCap)) begin
                    out_iter_d  = iter_q;
                    out_x_d     = x_q;
                    out_y_d     = y_q;
                    out_valid_d = 1'b1;
                    state_d     = StEmit;
                end else begin
                    zr_d   = zr_next;
                    zi_d   = zi_next;
                    iter_d = iter_q + ITER_W'(1);
                end
            end
            StEmit: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (x_q != LastX) begin
                        x_d      = x_q + 8'd1;
                        cur_re_d = cur_re_q + STEP;
                        state_d  = StInit;
                    end else if (y_q != LastY) begin
                        x_d      = '0;
                        y_d      = y_q + 8'd1;
                        cur_re_d = X_MIN;
                        cur_im_d = cur_im_q - STEP;
                        state_d  = StInit;
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = StDone;
                    end
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cr_q         <= '0;
            ci_q         <= '0;
            zr_q         <= '0;
            zi_q         <= '0;
            cur_re_q     <= '0;
            cur_im_q     <= '0;
            iter_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_iter_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cr_q         <= cr_d;
            ci_q         <= ci_d;
            zr_q         <= zr_d;
            zi_q         <= zi_d;
            cur_re_q     <= cur_re_d;
            cur_im_q     <= cur_im_d;
            iter_q       <= iter_d;
            x_q          <= x_d;
            y_q          <= y_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_iter_q   <= out_iter_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_iter   = out_iter_q;
    assign frame_done = frame_done_q;

endmodule
